// File: rtl/rng_arb_pkg.sv
// Shared types and helpers for the rng range arbiter.
package rng_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Round-robin increment that wraps at n, so non-power-of-2 counts work.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        int unsigned nxt;
        nxt = ptr + 32'd1;
        if (nxt >= n) begin
            nxt = 32'd0;
        end else begin
            nxt = ptr + 32'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rng_arb_chk.sv
// Protocol and structural checks for rng_arb.
module rng_arb_chk #(
    parameter int NUM_REQ    = 4,
    parameter int W_CFG      = 48,
    parameter int W_DOUT     = 17,
    parameter int W_ID       = 2,
    parameter int W_CFG_PORT = 48,
    parameter int W_DO_PORT  = 19
) (
    input logic                   clk,
    input logic                   rst,
    input logic                   busy,
    input logic [W_ID-1:0]        grant,
    input logic [NUM_REQ-1:0]     cfg_in_valid,
    input logic [NUM_REQ-1:0]     cfg_in_ready,
    input logic                   dout_valid,
    input logic [W_ID+W_DOUT-1:0] dout_data
);

    logic hold_q;
    logic hold_d;

    // Granted requester is showing valid without ready: it must keep valid next cycle.
    always_comb begin
        hold_d = busy & cfg_in_valid[grant] & ~cfg_in_ready[grant];
    end

    // Remember an outstanding granted request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
        end
    end

    a_shape: assert property (@(posedge clk)
        (W_CFG_PORT == W_CFG) && (W_DO_PORT == W_ID + W_DOUT) && (NUM_REQ >= 2));

    a_valid_hold: assert property (@(posedge clk) disable iff (rst)
        hold_q |-> cfg_in_valid[grant]);

    a_tag: assert property (@(posedge clk) disable iff (rst)
        dout_valid |-> (dout_data[W_ID+W_DOUT-1:W_DOUT] == grant));

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit at ptr, ptr+1, ... (mod N).
module rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         any
);

    localparam int unsigned N_U = N;

    // Scan from the farthest offset back to ptr so the nearest requester wins.
    always_comb begin
        int unsigned  cand;
        logic [W-1:0] cidx;
        cand = 32'd0;
        cidx = '0;
        idx  = '0;
        any  = |req;
        for (int unsigned k = N_U; k > 32'd0; k--) begin
            cand = 32'(ptr) + k - 32'd1;
            cand = (cand >= N_U) ? (cand - N_U) : cand;
            cidx = W'(cand);
            idx  = req[cidx] ? cidx : idx;
        end
    end

endmodule

// File: rtl/rng_arb.sv
// Shares one rng between NUM_REQ requesters; grant is held from cfg forward to the eot beat.
module rng_arb
    import rng_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int W_CFG   = 48,
    parameter  int W_DOUT  = 17,
    localparam int W_ID    = $clog2(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              cfg_in_valid,
    output logic [NUM_REQ-1:0]              cfg_in_ready,
    input  logic [NUM_REQ-1:0][W_CFG-1:0]   cfg_in_data,
    output logic                            cfg_out_valid,
    input  logic                            cfg_out_ready,
    output logic [W_CFG-1:0]                cfg_out_data,
    input  logic                            rng_in_valid,
    output logic                            rng_in_ready,
    input  logic [W_DOUT-1:0]               rng_in_data,
    output logic                            dout_valid,
    input  logic                            dout_ready,
    output logic [W_ID+W_DOUT-1:0]          dout_data
);

    arb_state_e      state_q, state_d;
    logic [W_ID-1:0] grant_q, grant_d;
    logic [W_ID-1:0] rr_ptr_q, rr_ptr_d;
    logic [W_ID-1:0] pick_idx;
    logic            pick_any;
    logic            eot_hs;

    rr_pick #(.N(NUM_REQ), .W(W_ID)) u_pick (
        .req (cfg_in_valid),
        .ptr (rr_ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Next state: arbitrate in IDLE (the one-cycle bubble), release on the eot handshake.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        eot_hs   = rng_in_valid & dout_ready & rng_in_data[W_DOUT-1];
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = BUSY;
                    grant_d = pick_idx;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (eot_hs) begin
                    state_d  = IDLE;
                    rr_ptr_d = W_ID'(rr_next(32'(grant_q), NUM_REQ));
                end else begin
                    state_d = BUSY;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Channel steering: only the granted requester sees the rng, everything idles otherwise.
    always_comb begin
        cfg_in_ready  = '0;
        cfg_out_valid = 1'b0;
        cfg_out_data  = '0;
        rng_in_ready  = 1'b0;
        dout_valid    = 1'b0;
        dout_data     = '0;
        case (state_q)
            BUSY: begin
                cfg_out_valid         = cfg_in_valid[grant_q];
                cfg_out_data          = cfg_in_data[grant_q];
                cfg_in_ready[grant_q] = cfg_out_ready;
                dout_valid            = rng_in_valid;
                dout_data             = {grant_q, rng_in_data};
                rng_in_ready          = dout_ready;
            end
            IDLE: begin
                cfg_out_valid = 1'b0;
            end
            default: begin
                cfg_out_valid = 1'b0;
            end
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    rng_arb_chk #(
        .NUM_REQ    (NUM_REQ),
        .W_CFG      (W_CFG),
        .W_DOUT     (W_DOUT),
        .W_ID       (W_ID),
        .W_CFG_PORT ($bits(cfg_out_data)),
        .W_DO_PORT  ($bits(dout_data))
    ) u_chk (
        .clk          (clk),
        .rst          (rst),
        .busy         (state_q == BUSY),
        .grant        (grant_q),
        .cfg_in_valid (cfg_in_valid),
        .cfg_in_ready (cfg_in_ready),
        .dout_valid   (dout_valid),
        .dout_data    (dout_data)
    );

endmodule

// File: tb/tb_rng_arb.sv
// Bench for rng_arb: per-cycle range-level model plus directed scenarios with literal beat lists.
module tb_rng_arb;

    localparam int N  = 4;
    localparam int WC = 48;
    localparam int WD = 17;
    localparam int WI = 2;
    localparam int WO = WI + WD;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      cin_valid, cin_ready;
    logic [N-1:0][WC-1:0] cin_data;
    logic              cout_valid, cout_ready;
    logic [WC-1:0]     cout_data;
    logic              rin_valid, rin_ready;
    logic [WD-1:0]     rin_data;
    logic              dout_valid, dout_ready;
    logic [WO-1:0]     dout_data;

    logic [2:0]        r3_valid, r3_ready;
    logic [2:0][WC-1:0] r3_data;
    logic              r3_cout_valid, r3_cout_ready;
    logic [WC-1:0]     r3_cout_data;
    logic              r3_rin_valid, r3_rin_ready;
    logic [WD-1:0]     r3_rin_data;
    logic              r3_dout_valid;
    logic [WO-1:0]     r3_dout_data;

    always #5 clk = ~clk;

    rng_arb #(.NUM_REQ(N), .W_CFG(WC), .W_DOUT(WD)) dut (
        .clk(clk), .rst(rst),
        .cfg_in_valid(cin_valid), .cfg_in_ready(cin_ready), .cfg_in_data(cin_data),
        .cfg_out_valid(cout_valid), .cfg_out_ready(cout_ready), .cfg_out_data(cout_data),
        .rng_in_valid(rin_valid), .rng_in_ready(rin_ready), .rng_in_data(rin_data),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data)
    );

    rng_arb #(.NUM_REQ(3), .W_CFG(WC), .W_DOUT(WD)) dut3 (
        .clk(clk), .rst(rst),
        .cfg_in_valid(r3_valid), .cfg_in_ready(r3_ready), .cfg_in_data(r3_data),
        .cfg_out_valid(r3_cout_valid), .cfg_out_ready(r3_cout_ready), .cfg_out_data(r3_cout_data),
        .rng_in_valid(r3_rin_valid), .rng_in_ready(r3_rin_ready), .rng_in_data(r3_rin_data),
        .dout_valid(r3_dout_valid), .dout_ready(1'b1), .dout_data(r3_dout_data)
    );

    // Simple rng (non-step): cfg = {incr, cnt, base}; emits base + k*incr, eot on beat cnt-1.
    logic [15:0] rk;
    logic [15:0] r_incr, r_cnt, r_base;
    assign r_incr     = cout_data[47:32];
    assign r_cnt      = cout_data[31:16];
    assign r_base     = cout_data[15:0];
    assign rin_valid  = cout_valid;
    assign rin_data   = {rk == (r_cnt - 16'd1), 16'(r_base + rk * r_incr)};
    assign cout_ready = rin_valid & rin_ready & rin_data[WD-1];

    always @(posedge clk or posedge rst) begin
        if (rst) rk <= 16'd0;
        else if (rin_valid && rin_ready) rk <= rin_data[WD-1] ? 16'd0 : rk + 16'd1;
    end

    // Single-beat rng for the 3-requester instance.
    assign r3_rin_valid  = r3_cout_valid;
    assign r3_rin_data   = {1'b1, r3_cout_data[15:0]};
    assign r3_cout_ready = r3_rin_valid & r3_rin_ready;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int cr_cnt [N];
    logic [WC-1:0] rq [N][$];
    logic [N-1:0]  pop_r;
    logic [2:0]    pop3;
    logic [WO-1:0] log_d [$];
    int            log_t [$];
    logic [WO-1:0] log3 [$];
    logic [WO-1:0] exp_q [$];
    bit            rdy_rand;
    bit            m_busy;
    int            m_grant, m_ptr, m_k;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [WC-1:0] mkcfg(input int incr, input int cnt, input int base);
        return {16'(incr), 16'(cnt), 16'(base)};
    endfunction

    // Expected beats of one whole range, tagged with the requester id.
    task automatic push_exp(input int id, input int incr, input int cnt, input int base);
        for (int k = 0; k < cnt; k++)
            exp_q.push_back(WO'((id << 17) | ((k == cnt - 1) ? (1 << 16) : 0) | ((base + k * incr) & 16'hFFFF)));
    endtask

    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            cin_valid[i] = rq[i].size() > 0;
            cin_data[i]  = (rq[i].size() > 0) ? rq[i][0] : '0;
        end
    endtask

    // One clock: compare at negedge against the model, advance the model, drive after posedge.
    task automatic step();
        logic [N-1:0]  ecr;
        logic [WO-1:0] edd;
        logic [WC-1:0] c;
        bit edv, ecv, err, eot, v, found;
        int g;
        @(negedge clk);
        cyc++;
        ecr = '0; edd = '0; edv = 1'b0; ecv = 1'b0; err = 1'b0; eot = 1'b0; v = 1'b0;
        g = m_grant;
        c = cin_data[g];
        if (!rst && m_busy) begin
            v   = cin_valid[g];
            eot = (m_k == int'(c[31:16]) - 1);
            edv = v; ecv = v; err = dout_ready;
            if (v && dout_ready && eot) ecr[g] = 1'b1;
            edd = {2'(g), eot, 16'(c[15:0] + 16'(m_k) * c[47:32])};
        end
        chk("ctl", 64'({dout_valid, cout_valid, rin_ready, cin_ready}), 64'({edv, ecv, err, ecr}));
        if (edv) begin
            chk("dout", 64'(dout_data), 64'(edd));
            chk("cfg_out", 64'(cout_data), 64'(c));
        end
        for (int i = 0; i < N; i++) if (cin_ready[i]) cr_cnt[i]++;
        if (dout_valid && dout_ready) begin
            log_d.push_back(dout_data);
            log_t.push_back(cyc);
        end
        if (r3_dout_valid) log3.push_back(r3_dout_data);
        pop_r = cin_valid & cin_ready;
        pop3  = r3_valid & r3_ready;
        if (rst) begin
            m_busy = 1'b0; m_ptr = 0; m_grant = 0; m_k = 0;
        end else if (!m_busy) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (!found && cin_valid[idx]) begin
                    found = 1'b1;
                    m_grant = idx;
                end
            end
            m_busy = found;
            m_k = 0;
        end else if (cin_valid[g] && dout_ready) begin
            if (eot) begin
                m_busy = 1'b0; m_ptr = (g + 1) % N; m_k = 0;
            end else begin
                m_k++;
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (pop_r[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        r3_valid   = r3_valid & ~pop3;
        dout_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        refresh();
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        bit busy;
        n = 0;
        busy = 1'b1;
        while (busy && n < budget) begin
            step();
            n++;
            busy = m_busy;
            for (int i = 0; i < N; i++) if (rq[i].size() > 0) busy = 1'b1;
        end
        chk({name, "_drained"}, 64'(busy), 64'(0));
    endtask

    task automatic cmp_log(input string name);
        chk({name, "_len"}, 64'(log_d.size()), 64'(exp_q.size()));
        for (int i = 0; i < log_d.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_beat%0d", name, i), 64'(log_d[i]), 64'(exp_q[i]));
    endtask

    task automatic clear_logs();
        log_d.delete(); log_t.delete(); log3.delete(); exp_q.delete();
        for (int i = 0; i < N; i++) cr_cnt[i] = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_logs();
    endtask

    initial begin
        int t_rel, wait_n;
        rst = 1'b1; dout_ready = 1'b1; rdy_rand = 1'b0; r3_valid = '0;
        m_busy = 1'b0; m_grant = 0; m_ptr = 0; m_k = 0;
        for (int i = 0; i < 3; i++) r3_data[i] = mkcfg(0, 1, 16'hA0 + i);
        refresh();
        clear_logs();

        // Reset state, with a request already pending.
        rq[1].push_back(mkcfg(1, 3, 0));
        rq[1].push_back(mkcfg(1, 3, 0));
        refresh();
        #1;
        chk("rst_state", 64'({dout_valid, cout_valid, rin_ready, cin_ready}), 64'(0));
        step(); step();
        rst = 1'b0;
        clear_logs();
        t_rel = cyc;

        // Single requester, two back-to-back ranges of {incr=1,cnt=3,base=0}.
        drain("t1", 40);
        exp_q = '{19'h20000, 19'h20001, 19'h30002, 19'h20000, 19'h20001, 19'h30002};
        cmp_log("t1");
        if (log_t.size() == 6) begin
            chk("t1_first_beat_cycle", 64'(log_t[0] - t_rel), 64'(2));
            chk("t1_regrant_gap", 64'(log_t[3] - log_t[2]), 64'(2));
        end
        chk("t1_ready_pulses", 64'(cr_cnt[1]), 64'(2));

        // All four requesters at once from reset: order 0,1,2,3 without interleave.
        rst = 1'b1;
        for (int i = 0; i < N; i++) rq[i].push_back(mkcfg(1, 2, 16 * i));
        refresh();
        step();
        rst = 1'b0;
        clear_logs();
        drain("t2", 60);
        for (int i = 0; i < N; i++) push_exp(i, 1, 2, 16 * i);
        cmp_log("t2");

        // Fairness: req2 arrives while req0 is busy and wins the next slot.
        do_reset();
        for (int r = 0; r < 3; r++) rq[0].push_back(mkcfg(2, 3, 16'h100));
        refresh();
        step(); step();
        rq[2].push_back(mkcfg(1, 2, 16'h200));
        refresh();
        drain("t3", 80);
        push_exp(0, 2, 3, 16'h100);
        push_exp(2, 1, 2, 16'h200);
        push_exp(0, 2, 3, 16'h100);
        push_exp(0, 2, 3, 16'h100);
        cmp_log("t3");

        // Random dout backpressure over a 5-beat range.
        do_reset();
        rdy_rand = 1'b1;
        rq[3].push_back(mkcfg(3, 5, 16'h40));
        refresh();
        drain("t4", 200);
        rdy_rand = 1'b0;
        dout_ready = 1'b1;
        exp_q = '{19'h60040, 19'h60043, 19'h60046, 19'h60049, 19'h7004C};
        cmp_log("t4");

        // Reset mid-range after two beats, then the range restarts from beat 0.
        do_reset();
        rq[2].push_back(mkcfg(1, 5, 0));
        refresh();
        wait_n = 0;
        while (log_d.size() < 2 && wait_n < 20) begin
            step();
            wait_n++;
        end
        chk("t5_two_beats", 64'(log_d.size()), 64'(2));
        chk("t5_pre_rst_valid", 64'(dout_valid), 64'(1));
        rst = 1'b1;
        #1;
        chk("t5_async_rst", 64'({dout_valid, cout_valid, rin_ready, cin_ready}), 64'(0));
        step();
        rst = 1'b0;
        clear_logs();
        drain("t5", 40);
        push_exp(2, 1, 5, 0);
        cmp_log("t5");

        // Three requesters: req2 first, then req0/req1; pointer wraps 2 -> 0.
        do_reset();
        r3_valid = 3'b100;
        step();
        r3_valid = r3_valid | 3'b011;
        repeat (8) step();
        chk("t6_len", 64'(log3.size()), 64'(3));
        if (log3.size() == 3) begin
            chk("t6_beat0", 64'(log3[0]), 64'(19'h500A2));
            chk("t6_beat1", 64'(log3[1]), 64'(19'h100A0));
            chk("t6_beat2", 64'(log3[2]), 64'(19'h300A1));
        end
        chk("t6_all_served", 64'(r3_valid), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
